neutron_pulse_writer: RTL and testbench

NEUTRON_PULSE_WRITER -- requirements
Module: neutron_pulse_writer

---
 rtl/neutron_pkg.sv | 27 ++
 rtl/neutron_pulse_writer_window_fifo.sv | 92 +++++++++
 rtl/neutron_pulse_writer.sv | 173 +++++++++++++++++
 tb/tb_neutron_pulse_writer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neutron_pkg.sv
// neutron_pkg: shared GLOBAL_STATE codes and the pulse-writer state encoding.
package neutron_pkg;

    // System-wide state broadcast on GLOBAL_STATE.
    typedef enum logic [2:0] {
        GS_SOFTRESET = 3'b000,
        GS_WAITING   = 3'b001,
        GS_TRIGGERED = 3'b010,
        GS_FLAGGED   = 3'b100,
        GS_READOUT   = 3'b101,
        GS_HOLDOFF   = 3'b110,
        GS_CUSTOM    = 3'b111
    } global_state_e;

    // Pulse writer control states.
    typedef enum logic [1:0] {
        WR_IDLE   = 2'b00,
        WR_ARMED  = 2'b01,
        WR_ACTIVE = 2'b10
    } writer_state_e;

    // True when the system requests a soft reset.
    function automatic logic is_soft_reset(input logic [2:0] gs);
        return gs == GS_SOFTRESET;
    endfunction

endpackage

// File: rtl/neutron_pulse_writer_window_fifo.sv
// window_fifo: DEPTH-entry queue of {start, end} windows with synchronous flush.
//   clk_i, rst_ni  : clock, async active-low reset
//   flush_i        : empties the queue on the next edge (overrides push/pop)
//   push_i/wdata_i : enqueue at tail when not full
//   pop_i          : dequeue head when not empty
//   head_c         : current head entry (combinational)
//   empty_c        : queue empty now
//   full_next_c    : queue will be full after this edge
//   empty_next_c   : queue will be empty after this edge
module window_fifo
    import neutron_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_c,
    output logic             empty_c,
    output logic             full_next_c,
    output logic             empty_next_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]    count_q, count_d;
    logic             full_c;
    logic             push_ok;
    logic             pop_ok;

    assign full_c  = (count_q == NW'(DEPTH));
    assign empty_c = (count_q == '0);
    assign push_ok = push_i && !full_c && !flush_i;
    assign pop_ok  = pop_i && !empty_c && !flush_i;
    assign head_c  = mem_q[rd_ptr_q];

    // Pointer/occupancy next state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + NW'(1);
                2'b01:   count_d = count_q - NW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    assign full_next_c  = (count_d == NW'(DEPTH));
    assign empty_next_c = (count_d == '0);

    // Control registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/neutron_pulse_writer.sv
// neutron_pulse_writer: queues {start, end} bin windows and drives PULSE high from the
// cycle after COUNT == start until the cycle after COUNT == end, then strobes DONE.
//   CLK, RESET_N          : clock, async active-low reset
//   COUNT                 : free-running bin counter
//   GLOBAL_STATE          : system state, 3'b000 = synchronous soft reset
//   WIN_VALID/WIN_READY   : window handshake; WIN_START/WIN_END window bins
//   PULSE, BUSY, DONE     : registered pulse, activity flag, completion strobe
//   PULSE_COUNT           : saturating DONE counter, present only when
//                           NEUTRON_PULSE_WRITER_STATS_EN is defined
module neutron_pulse_writer
    import neutron_pkg::*;
#(
    parameter int unsigned CW    = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic [CW-1:0] COUNT,
    input  logic [2:0]    GLOBAL_STATE,
    input  logic          WIN_VALID,
    output logic          WIN_READY,
    input  logic [CW-1:0] WIN_START,
    input  logic [CW-1:0] WIN_END,
    output logic          PULSE,
    output logic          BUSY,
    output logic          DONE
`ifdef NEUTRON_PULSE_WRITER_STATS_EN
    ,
    output logic [15:0]   PULSE_COUNT
`endif
);

    localparam int unsigned QW = 2 * CW;

    writer_state_e state_q, state_d;
    logic [CW-1:0] cur_start_q, cur_start_d;
    logic [CW-1:0] cur_end_q, cur_end_d;
    logic          single_q, single_d;
    logic          pulse_q, pulse_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    logic          soft_c;
    logic          push_c;
    logic          pop_c;
    logic [QW-1:0] head_c;
    logic          empty_c;
    logic          full_next_c;
    logic          empty_next_c;

    assign soft_c = is_soft_reset(GLOBAL_STATE);
    assign push_c = WIN_VALID && ready_q && !soft_c;

    window_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (CLK),
        .rst_ni       (RESET_N),
        .flush_i      (soft_c),
        .push_i       (push_c),
        .pop_i        (pop_c),
        .wdata_i      ({WIN_START, WIN_END}),
        .head_c       (head_c),
        .empty_c      (empty_c),
        .full_next_c  (full_next_c),
        .empty_next_c (empty_next_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cur_start_d = cur_start_q;
        cur_end_d   = cur_end_q;
        single_d    = single_q;
        pulse_d     = pulse_q;
        done_d      = 1'b0;
        pop_c       = 1'b0;

        if (soft_c) begin
            // Truncate any pulse in progress without a DONE strobe.
            state_d = WR_IDLE;
            pulse_d = 1'b0;
        end else begin
            case (state_q)
                WR_IDLE: begin
                    if (!empty_c) begin
                        pop_c       = 1'b1;
                        cur_start_d = head_c[QW-1:CW];
                        cur_end_d   = head_c[CW-1:0];
                        single_d    = (head_c[QW-1:CW] == head_c[CW-1:0]);
                        state_d     = WR_ARMED;
                    end
                end
                WR_ARMED: begin
                    if (COUNT == cur_start_q) begin
                        pulse_d = 1'b1;
                        state_d = WR_ACTIVE;
                    end
                end
                WR_ACTIVE: begin
                    // start == end windows last exactly one cycle.
                    if (single_q || (COUNT == cur_end_q)) begin
                        pulse_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = WR_IDLE;
                    end
                end
                default: begin
                    state_d = WR_IDLE;
                    pulse_d = 1'b0;
                end
            endcase
        end

        ready_d = !soft_c && !full_next_c;
        busy_d  = (state_d != WR_IDLE) || !empty_next_c;
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= WR_IDLE;
            cur_start_q <= '0;
            cur_end_q   <= '0;
            single_q    <= 1'b0;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_start_q <= cur_start_d;
            cur_end_q   <= cur_end_d;
            single_q    <= single_d;
            pulse_q     <= pulse_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign PULSE     = pulse_q;
    assign DONE      = done_q;
    assign BUSY      = busy_q;
    assign WIN_READY = ready_q;

`ifdef NEUTRON_PULSE_WRITER_STATS_EN
    logic [15:0] pcount_q, pcount_d;

    // Saturating count of completed pulses.
    always_comb begin
        pcount_d = pcount_q;
        if (soft_c) begin
            pcount_d = '0;
        end else if (done_d && (pcount_q != 16'hFFFF)) begin
            pcount_d = pcount_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pcount_q <= '0;
        end else begin
            pcount_q <= pcount_d;
        end
    end

    assign PULSE_COUNT = pcount_q;
`endif

endmodule

// File: tb/tb_neutron_pulse_writer.sv
// Self-checking bench for neutron_pulse_writer: directed spec scenarios plus randomized
// window streams compared against a timeline model built from the window rules.
module tb_neutron_pulse_writer;

    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 2;
    localparam int          MAXW  = 16;

    logic          CLK;
    logic          RESET_N;
    logic [CW-1:0] COUNT;
    logic [2:0]    GLOBAL_STATE;
    logic          WIN_VALID;
    logic          WIN_READY;
    logic [CW-1:0] WIN_START;
    logic [CW-1:0] WIN_END;
    logic          PULSE;
    logic          BUSY;
    logic          DONE;
`ifdef NEUTRON_PULSE_WRITER_STATS_EN
    logic [15:0]   PULSE_COUNT;
`endif

    neutron_pulse_writer #(
        .CW    (CW),
        .DEPTH (DEPTH)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .COUNT        (COUNT),
        .GLOBAL_STATE (GLOBAL_STATE),
        .WIN_VALID    (WIN_VALID),
        .WIN_READY    (WIN_READY),
        .WIN_START    (WIN_START),
        .WIN_END      (WIN_END),
        .PULSE        (PULSE),
        .BUSY         (BUSY),
        .DONE         (DONE)
`ifdef NEUTRON_PULSE_WRITER_STATS_EN
        ,
        .PULSE_COUNT  (PULSE_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Scenario description and derived timeline (edge indices relative to scenario start).
    int          nwin;
    int          w_offer [MAXW];
    int unsigned w_start [MAXW];
    int unsigned w_end   [MAXW];
    int          p_at    [MAXW];   // edge the window is accepted
    int          a_at    [MAXW];   // edge the window arms
    int          r_at    [MAXW];   // edge PULSE rises
    int          f_at    [MAXW];   // edge PULSE falls / DONE rises
    int unsigned c0;               // COUNT presented at scenario edge 0
    bit          gen_rand;
    int          hi_cycles;
    int          done_cycles;
    int          exp_pc;

    logic [2:0] gs_ok [6] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        COUNT = COUNT + CW'(1);
    endtask

    // First edge after 'after_t' at which COUNT equals val (COUNT advances one bin per edge).
    function automatic int next_hit(input int after_t, input int unsigned val);
        int unsigned cnow;
        cnow = (c0 + int'(after_t) + 1) % 65536;
        return after_t + 1 + int'((val + 65536 - cnow) % 65536);
    endfunction

    // Timeline: accept when DEPTH-older window has left the queue, arm one edge after
    // accept or the edge after the previous fall, rise on start hit, fall on end hit.
    task automatic build_model();
        for (int k = 0; k < nwin; k++) begin
            int e;
            e = w_offer[k];
            if (k > 0 && p_at[k-1] + 1 > e) e = p_at[k-1] + 1;
            if (k >= int'(DEPTH) && a_at[k-int'(DEPTH)] + 1 > e) e = a_at[k-int'(DEPTH)] + 1;
            p_at[k] = e;
            a_at[k] = p_at[k] + 1;
            if (k > 0 && f_at[k-1] + 1 > a_at[k]) a_at[k] = f_at[k-1] + 1;
            if (gen_rand) begin
                w_start[k] = (c0 + int'(a_at[k]) + 1 + $urandom_range(0, 12)) % 65536;
                w_end[k]   = (w_start[k] + $urandom_range(0, 15)) % 65536;
            end
            r_at[k] = next_hit(a_at[k], w_start[k]);
            f_at[k] = (w_start[k] == w_end[k]) ? r_at[k] + 1 : next_hit(r_at[k], w_end[k]);
        end
    endtask

    task automatic run_scenario(input string tag);
        int kd;
        int t_end;
        int occ;
        bit rdy_prev;
        bit acc;
        bit exp_pulse;
        bit exp_done;
        bit exp_busy;
        build_model();
        t_end       = f_at[nwin-1] + 3;
        kd          = 0;
        hi_cycles   = 0;
        done_cycles = 0;
        COUNT       = CW'(c0);
        rdy_prev    = WIN_READY;
        for (int t = 0; t <= t_end; t++) begin
            if (kd < nwin && t >= w_offer[kd]) begin
                WIN_VALID = 1'b1;
                WIN_START = CW'(w_start[kd]);
                WIN_END   = CW'(w_end[kd]);
            end else begin
                WIN_VALID = 1'b0;
            end
            GLOBAL_STATE = gs_ok[$urandom_range(0, 5)];
            @(posedge CLK);
            #1;
            acc = WIN_VALID && rdy_prev;
            if (WIN_VALID) check({tag, "_accept"}, 32'(acc), 32'(t == p_at[kd]));
            if (acc) kd++;
            exp_pulse = 1'b0;
            exp_done  = 1'b0;
            exp_busy  = 1'b0;
            occ       = 0;
            for (int k = 0; k < nwin; k++) begin
                if (r_at[k] <= t && t < f_at[k]) exp_pulse = 1'b1;
                if (f_at[k] == t) exp_done = 1'b1;
                if (p_at[k] <= t && t < f_at[k]) exp_busy = 1'b1;
                if (p_at[k] <= t && t < a_at[k]) occ++;
            end
            check({tag, "_pulse"}, 32'(PULSE), 32'(exp_pulse));
            check({tag, "_done"},  32'(DONE),  32'(exp_done));
            check({tag, "_busy"},  32'(BUSY),  32'(exp_busy));
            check({tag, "_ready"}, 32'(WIN_READY), 32'(occ != int'(DEPTH)));
            hi_cycles   += int'(PULSE);
            done_cycles += int'(DONE);
            rdy_prev = WIN_READY;
            COUNT    = CW'(c0 + int'(t) + 1);
        end
        WIN_VALID = 1'b0;
        exp_pc += nwin;
`ifdef NEUTRON_PULSE_WRITER_STATS_EN
        check({tag, "_pcount"}, 32'(PULSE_COUNT), 32'(exp_pc));
`endif
    endtask

    initial begin
        int pulses;
        int dones;
        int busies;

        // Async reset from a real falling edge; a window is offered throughout.
        RESET_N      = 1'b1;
        COUNT        = '0;
        GLOBAL_STATE = 3'b001;
        WIN_VALID    = 1'b1;
        WIN_START    = 16'd3;
        WIN_END      = 16'd4;
        exp_pc       = 0;
        gen_rand     = 1'b0;
        #2 RESET_N = 1'b0;
        #10;
        check("rst_pulse", 32'(PULSE), 32'd0);
        check("rst_done",  32'(DONE),  32'd0);
        check("rst_busy",  32'(BUSY),  32'd0);
        check("rst_ready", 32'(WIN_READY), 32'd0);
`ifdef NEUTRON_PULSE_WRITER_STATS_EN
        check("rst_pcount", 32'(PULSE_COUNT), 32'd0);
`endif
        #10 RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        check("rel_ready", 32'(WIN_READY), 32'd1);
        check("rel_busy",  32'(BUSY), 32'd0);
        WIN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        check("rel_noaccept", 32'(BUSY), 32'd0);

        // Window (10,14): four-cycle pulse, one DONE.
        nwin = 1; c0 = 0; w_offer[0] = 0; w_start[0] = 10; w_end[0] = 14;
        run_scenario("w10_14");
        check("w10_14_width", 32'(hi_cycles), 32'd4);
        check("w10_14_ndone", 32'(done_cycles), 32'd1);

        // Window (7,7): single-cycle pulse.
        nwin = 1; c0 = 0; w_offer[0] = 0; w_start[0] = 7; w_end[0] = 7;
        run_scenario("w7_7");
        check("w7_7_width", 32'(hi_cycles), 32'd1);
        check("w7_7_ndone", 32'(done_cycles), 32'd1);

        // Window across the COUNT wrap.
        nwin = 1; c0 = 32'hFFF0; w_offer[0] = 0; w_start[0] = 32'hFFFE; w_end[0] = 2;
        run_scenario("wrap");
        check("wrap_width", 32'(hi_cycles), 32'd4);

        // Three windows offered together, second starting two cycles after first falls.
        nwin = 3; c0 = 0;
        w_offer[0] = 0; w_start[0] = 5;  w_end[0] = 8;
        w_offer[1] = 0; w_start[1] = 10; w_end[1] = 12;
        w_offer[2] = 0; w_start[2] = 20; w_end[2] = 22;
        run_scenario("three");
        check("three_width", 32'(hi_cycles), 32'd7);
        check("three_ndone", 32'(done_cycles), 32'd3);

        // Four windows: the fourth stalls on a full queue.
        nwin = 4; c0 = 100;
        w_offer[0] = 0; w_start[0] = 105; w_end[0] = 108;
        w_offer[1] = 0; w_start[1] = 112; w_end[1] = 113;
        w_offer[2] = 0; w_start[2] = 120; w_end[2] = 122;
        w_offer[3] = 0; w_start[3] = 125; w_end[3] = 126;
        run_scenario("four");
        check("four_ndone", 32'(done_cycles), 32'd4);

        // Soft reset in the middle of pulse (100,200) with a second window queued.
        GLOBAL_STATE = 3'b010;
        COUNT     = 16'd90;
        WIN_VALID = 1'b1;
        WIN_START = 16'd100;
        WIN_END   = 16'd200;
        tick();
        WIN_START = 16'd300;
        WIN_END   = 16'd310;
        tick();
        WIN_VALID = 1'b0;
        for (int i = 0; i < 60 && COUNT != 16'd150; i++) tick();
        check("sr_pre_pulse", 32'(PULSE), 32'd1);
        check("sr_pre_busy",  32'(BUSY),  32'd1);
        GLOBAL_STATE = 3'b000;
        tick();
        exp_pc = 0;
        check("sr_pulse", 32'(PULSE), 32'd0);
        check("sr_done",  32'(DONE),  32'd0);
        check("sr_busy",  32'(BUSY),  32'd0);
        check("sr_ready", 32'(WIN_READY), 32'd0);
`ifdef NEUTRON_PULSE_WRITER_STATS_EN
        check("sr_pcount", 32'(PULSE_COUNT), 32'd0);
`endif
        tick();
        check("sr_hold_done",  32'(DONE), 32'd0);
        check("sr_hold_ready", 32'(WIN_READY), 32'd0);
        GLOBAL_STATE = 3'b001;
        tick();
        check("sr_exit_ready", 32'(WIN_READY), 32'd1);
        check("sr_exit_busy",  32'(BUSY), 32'd0);
        pulses = 0; dones = 0; busies = 0;
        for (int i = 0; i < 200 && COUNT != 16'd320; i++) begin
            tick();
            pulses += int'(PULSE);
            dones  += int'(DONE);
            busies += int'(BUSY);
        end
        check("sr_flushed_pulse", 32'(pulses), 32'd0);
        check("sr_flushed_done",  32'(dones),  32'd0);
        check("sr_flushed_busy",  32'(busies), 32'd0);

        // Async reset between edges while ACTIVE.
        COUNT     = 16'd1000;
        WIN_VALID = 1'b1;
        WIN_START = 16'd1003;
        WIN_END   = 16'd1003;
        tick();
        WIN_START = 16'd1010;
        WIN_END   = 16'd1050;
        tick();
        WIN_VALID = 1'b0;
        for (int i = 0; i < 30 && COUNT != 16'd1020; i++) tick();
        check("ar_pre_pulse", 32'(PULSE), 32'd1);
`ifdef NEUTRON_PULSE_WRITER_STATS_EN
        check("ar_pre_pcount", 32'(PULSE_COUNT), 32'd1);
`endif
        #3 RESET_N = 1'b0;
        #1;
        check("ar_pulse", 32'(PULSE), 32'd0);
        check("ar_done",  32'(DONE),  32'd0);
        check("ar_busy",  32'(BUSY),  32'd0);
        check("ar_ready", 32'(WIN_READY), 32'd0);
`ifdef NEUTRON_PULSE_WRITER_STATS_EN
        check("ar_pcount", 32'(PULSE_COUNT), 32'd0);
`endif
        exp_pc    = 0;
        WIN_VALID = 1'b1;
        WIN_START = 16'd1025;
        WIN_END   = 16'd1026;
        #2 RESET_N = 1'b1;
        tick();
        check("ar_rel_ready", 32'(WIN_READY), 32'd1);
        check("ar_rel_busy",  32'(BUSY), 32'd0);
        WIN_VALID = 1'b0;
        tick();
        check("ar_rel_noaccept", 32'(BUSY), 32'd0);

        // Randomized window streams.
        gen_rand = 1'b1;
        for (int s = 0; s < 8; s++) begin
            c0   = $urandom_range(0, 65535);
            nwin = int'($urandom_range(1, 6));
            w_offer[0] = int'($urandom_range(0, 3));
            for (int k = 1; k < nwin; k++) w_offer[k] = w_offer[k-1] + int'($urandom_range(0, 6));
            run_scenario($sformatf("rnd%0d", s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
